prog_loader: RTL

- Upstream boot stage of the miniRV single-cycle core.
- Accepts a framed byte stream over a valid/ready interface, assembles little-endian 32-bit words and writes them into instruction memory.
- Holds the core in reset while loading. Releases it only after the frame's length check and checksum both pass.
- Sits between the host byte source (UART RX / testbench) and the instruction memory write port plus the core's reset input.

---
 rtl/prog_loader_if.sv | 20 ++
 rtl/prog_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bus for the boot loader.
// The loader side uses the slave modport; the host/memory side uses master.
interface prog_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, writes little-endian
// words into instruction memory and releases the core only after a verified load.
module prog_loader #(
   parameter int          IMEM_WORDS = 256,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   prog_loader_if.slave bus,
   output logic         o_core_hold,
   output logic         o_done,
   output logic         o_error
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_LO = 3'd1;
   localparam logic [2:0] ST_LEN_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_CSUM   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;

   localparam logic [16:0] LP_MAX_WORDS = 17'(IMEM_WORDS);

   logic [2:0]  r_state;
   logic [15:0] r_len;
   logic [15:0] r_word_idx;
   logic [1:0]  r_byte_idx;
   logic [7:0]  r_csum;
   logic [23:0] r_word;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_in_ready;
   logic        w_xfer;
   logic [15:0] w_len_next;

   // NOTE: every output here is a decode of the state register alone, and each is
   // assigned a default first so no path through the case can leave one unassigned.
   always_comb begin
      w_in_ready  = 1'b0;
      o_core_hold = 1'b1;
      o_done      = 1'b0;
      o_error     = 1'b0;
      case (r_state)
         ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: w_in_ready = 1'b1;
         ST_DONE: begin
            o_core_hold = 1'b0;
            o_done      = 1'b1;
         end
         ST_ERR:  o_error = 1'b1;
         default: ;
      endcase
   end

   assign w_xfer     = bus.in_valid && w_in_ready;
   assign w_len_next = {bus.in_data, r_len[7:0]};

   assign bus.in_ready   = w_in_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;

   // NOTE: all state updates use non-blocking assignment so every register samples
   // the pre-edge values, independent of statement order within this block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_len      <= '0;
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_csum     <= '0;
         r_word     <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (i_start) begin
                  r_state    <= ST_LEN_LO;
                  r_csum     <= '0;
                  r_byte_idx <= '0;
                  r_word_idx <= '0;
               end
            end

            ST_LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= bus.in_data;
                  r_state    <= ST_LEN_HI;
               end
            end

            ST_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= bus.in_data;
                  if ({1'b0, w_len_next} > LP_MAX_WORDS) begin
                     r_state <= ST_ERR;
                  end else if (w_len_next == 16'd0) begin
                     r_state <= ST_CSUM;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (w_xfer) begin
                  r_csum     <= r_csum + bus.in_data;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     // Top byte goes straight to the write register; no lane storage.
                     r_we       <= 1'b1;
                     r_wdata    <= {bus.in_data, r_word};
                     r_addr     <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                     r_word_idx <= r_word_idx + 16'd1;
                     if (r_word_idx == r_len - 16'd1) begin
                        r_state <= ST_CSUM;
                     end
                  end else begin
                     r_word[{r_byte_idx, 3'b000} +: 8] <= bus.in_data;
                  end
               end
            end

            ST_CSUM: begin
               if (w_xfer) begin
                  r_state <= (bus.in_data == r_csum) ? ST_DONE : ST_ERR;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
